// File: rtl/gcd_stein_n.sv
// gcd_stein_n -- iterative binary (Stein) GCD engine, one reduction step per clock.
//
// Ports:
//   clk      system clock, all state changes on posedge
//   resetb   asynchronous reset, ACTIVE HIGH despite the name (1 = reset)
//   ld       load request; u and v are sampled on the edge where ld=1 and the engine is idle
//   u, v     operands (WIDTH bits)
//   res      GCD result, held until the next completion
//   done     one-cycle pulse on the edge res/steps/coprime are updated
//   busy     high while a computation is in flight
//   coprime  1 iff res == 1, registered together with res
//   steps    number of reduction steps of the last operation, registered with res
//
// Handshake: ld is a request qualified by !busy. While busy=1 ld is ignored
// and the operands are not resampled. Completion is signalled by a single
// done pulse; ld in that same cycle is accepted (engine is already idle),
// so operations can run back-to-back.
module gcd_stein_n #(
   parameter  int WIDTH = 8,
   localparam int SW    = $clog2(2 * WIDTH + 1),
   localparam int KW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             ld,
   input  logic [WIDTH-1:0] u,
   input  logic [WIDTH-1:0] v,
   output logic [WIDTH-1:0] res,
   output logic             done,
   output logic             busy,
   output logic             coprime,
   output logic [SW-1:0]    steps
);

   typedef enum logic {IDLE, CALC} state_t;

   state_t           state;
   logic [WIDTH-1:0] ur;
   logic [WIDTH-1:0] vr;
   logic [KW-1:0]    k;
   logic [SW-1:0]    cnt;

   // Final value once either working operand reaches zero: the surviving
   // operand scaled back by the common power of two. k never exceeds the
   // trailing zeros of the original operands, so the shift cannot overflow.
   logic [WIDTH-1:0] gcd_val;
   logic             ur_zero;
   logic             vr_zero;

   always_comb begin
      gcd_val = (ur | vr) << k;
      ur_zero = (ur == '0);
      vr_zero = (vr == '0);
   end

   always_ff @(posedge clk or posedge resetb) begin
      if (resetb) begin
         state   <= IDLE;
         ur      <= '0;
         vr      <= '0;
         k       <= '0;
         cnt     <= '0;
         res     <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         coprime <= 1'b0;
         steps   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (ld) begin
                  ur    <= u;
                  vr    <= v;
                  k     <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               if (ur_zero || vr_zero) begin
                  // Detection edge: publishes the result, not counted as a step.
                  res     <= gcd_val;
                  steps   <= cnt;
                  coprime <= (gcd_val == {{(WIDTH-1){1'b0}}, 1'b1});
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + SW'(1);
                  if (!ur[0] && !vr[0]) begin
                     ur <= ur >> 1;
                     vr <= vr >> 1;
                     k  <= k + KW'(1);
                  end else if (!ur[0]) begin
                     ur <= ur >> 1;
                  end else if (!vr[0]) begin
                     vr <= vr >> 1;
                  end else if (ur >= vr) begin
                     // Difference of two odd numbers is even, so halving loses nothing.
                     ur <= (ur - vr) >> 1;
                  end else begin
                     vr <= (vr - ur) >> 1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gcd_stein_n.sv
// Bench for gcd_stein_n: an 8-bit instance for the directed scenarios and a
// 16-bit instance for the wide and random cases. Expected GCDs come from a
// Euclid model and are queued when an operation is launched, then popped
// when the engine reports done.
module tb_gcd_stein_n;

   logic        clk = 1'b0;
   logic        resetb;

   logic        ld8;
   logic [7:0]  u8, v8, res8;
   logic        done8, busy8, cop8;
   logic [4:0]  steps8;

   logic        ld16;
   logic [15:0] u16, v16, res16;
   logic        done16, busy16, cop16;
   logic [5:0]  steps16;

   logic [15:0] exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   gcd_stein_n #(.WIDTH(8)) dut8 (
      .clk(clk), .resetb(resetb), .ld(ld8), .u(u8), .v(v8),
      .res(res8), .done(done8), .busy(busy8), .coprime(cop8), .steps(steps8)
   );

   gcd_stein_n #(.WIDTH(16)) dut16 (
      .clk(clk), .resetb(resetb), .ld(ld16), .u(u16), .v(v16),
      .res(res16), .done(done16), .busy(busy16), .coprime(cop16), .steps(steps16)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic logic [15:0] euclid(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   // Drivers: called at a negedge, launch one op, wait (bounded) for done.
   // lat counts edges from the load edge to the done edge; bz counts busy cycles.
   task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic [4:0] st,
                         output logic cp, output int lat, output int bz);
      ld8 = 1'b1; u8 = a; v8 = b;
      exp_q.push_back(euclid({8'd0, a}, {8'd0, b}));
      @(negedge clk);
      ld8 = 1'b0;
      lat = 0; bz = 0;
      while (!done8 && lat < 100) begin
         if (busy8) bz++;
         @(negedge clk);
         lat++;
      end
      r = res8; st = steps8; cp = cop8;
   endtask

   task automatic drive16(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic [5:0] st,
                          output logic seen);
      ld16 = 1'b1; u16 = a; v16 = b;
      exp_q.push_back(euclid(a, b));
      @(negedge clk);
      ld16 = 1'b0;
      for (int i = 0; i < 100 && !done16; i++) @(negedge clk);
      seen = done16;
      r = res16; st = steps16;
   endtask

   task automatic test_reset();
      resetb = 1'b1; ld8 = 0; u8 = 0; v8 = 0; ld16 = 0; u16 = 0; v16 = 0;
      repeat (2) @(negedge clk);
      n_cmp++; if (res8 !== 8'd0)   begin n_bad++; $display("FAIL reset_res got=%0d exp=0", res8); end
      n_cmp++; if (done8 !== 1'b0)  begin n_bad++; $display("FAIL reset_done got=%b exp=0", done8); end
      n_cmp++; if (busy8 !== 1'b0)  begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
      n_cmp++; if (cop8 !== 1'b0)   begin n_bad++; $display("FAIL reset_coprime got=%b exp=0", cop8); end
      n_cmp++; if (steps8 !== 5'd0) begin n_bad++; $display("FAIL reset_steps got=%0d exp=0", steps8); end
      resetb = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] r; logic [4:0] st; logic cp; int lat, bz; logic [15:0] e;
      drive8(8'd48, 8'd18, r, st, cp, lat, bz);
      e = exp_q.pop_front();
      n_cmp++; if (r !== e[7:0])  begin n_bad++; $display("FAIL basic_res got=%0d exp=%0d", r, e); end
      n_cmp++; if (st !== 5'd6)   begin n_bad++; $display("FAIL basic_steps got=%0d exp=6", st); end
      n_cmp++; if (cp !== 1'b0)   begin n_bad++; $display("FAIL basic_coprime got=%b exp=0", cp); end
      n_cmp++; if (lat != 7)      begin n_bad++; $display("FAIL basic_latency got=%0d exp=7", lat); end
      n_cmp++; if (bz != 7)       begin n_bad++; $display("FAIL basic_busy_cycles got=%0d exp=7", bz); end
      n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_fall got=%b exp=0", busy8); end
      @(negedge clk);
      n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got=%b exp=0", done8); end
   endtask

   task automatic test_mid_op_reset();
      int dn;
      logic [7:0] r; logic [4:0] st; logic cp; int lat, bz; logic [15:0] e;
      ld8 = 1'b1; u8 = 8'd48; v8 = 8'd18;
      @(negedge clk);
      ld8 = 1'b0;
      repeat (3) @(negedge clk);
      resetb = 1'b1;
      #1;
      n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", busy8); end
      n_cmp++; if (res8 !== 8'd0)  begin n_bad++; $display("FAIL midrst_res got=%0d exp=0", res8); end
      @(negedge clk);
      resetb = 1'b0;
      dn = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8) dn++;
      end
      n_cmp++; if (dn != 0) begin n_bad++; $display("FAIL midrst_no_done got=%0d exp=0", dn); end
      drive8(8'd48, 8'd18, r, st, cp, lat, bz);
      e = exp_q.pop_front();
      n_cmp++; if (r !== e[7:0]) begin n_bad++; $display("FAIL midrst_after_res got=%0d exp=%0d", r, e); end
      n_cmp++; if (lat != 7)     begin n_bad++; $display("FAIL midrst_after_lat got=%0d exp=7", lat); end
   endtask

   task automatic test_zero_operands();
      logic [7:0] r; logic [4:0] st; logic cp; int lat, bz; logic [15:0] e;
      drive8(8'd0, 8'd37, r, st, cp, lat, bz);
      e = exp_q.pop_front();
      n_cmp++; if (r !== e[7:0]) begin n_bad++; $display("FAIL zero_a_res got=%0d exp=%0d", r, e); end
      n_cmp++; if (st !== 5'd0)  begin n_bad++; $display("FAIL zero_a_steps got=%0d exp=0", st); end
      n_cmp++; if (lat != 1)     begin n_bad++; $display("FAIL zero_a_lat got=%0d exp=1", lat); end
      drive8(8'd0, 8'd0, r, st, cp, lat, bz);
      e = exp_q.pop_front();
      n_cmp++; if (r !== e[7:0]) begin n_bad++; $display("FAIL zero_both_res got=%0d exp=%0d", r, e); end
      n_cmp++; if (cp !== 1'b0)  begin n_bad++; $display("FAIL zero_both_coprime got=%b exp=0", cp); end
      n_cmp++; if (lat != 1)     begin n_bad++; $display("FAIL zero_both_lat got=%0d exp=1", lat); end
      drive8(8'd37, 8'd0, r, st, cp, lat, bz);
      e = exp_q.pop_front();
      n_cmp++; if (r !== e[7:0]) begin n_bad++; $display("FAIL zero_b_res got=%0d exp=%0d", r, e); end
      n_cmp++; if (lat != 1)     begin n_bad++; $display("FAIL zero_b_lat got=%0d exp=1", lat); end
   endtask

   task automatic test_pow2_equal();
      logic [7:0] r; logic [4:0] st; logic cp; int lat, bz; logic [15:0] e;
      drive8(8'd128, 8'd64, r, st, cp, lat, bz);
      e = exp_q.pop_front();
      n_cmp++; if (r !== e[7:0]) begin n_bad++; $display("FAIL pow2_res got=%0d exp=%0d", r, e); end
      n_cmp++; if (st !== 5'd8)  begin n_bad++; $display("FAIL pow2_steps got=%0d exp=8", st); end
      n_cmp++; if (lat != 9)     begin n_bad++; $display("FAIL pow2_lat got=%0d exp=9", lat); end
      drive8(8'd255, 8'd255, r, st, cp, lat, bz);
      e = exp_q.pop_front();
      n_cmp++; if (r !== e[7:0]) begin n_bad++; $display("FAIL equal_res got=%0d exp=%0d", r, e); end
      n_cmp++; if (st !== 5'd1)  begin n_bad++; $display("FAIL equal_steps got=%0d exp=1", st); end
      n_cmp++; if (lat != 2)     begin n_bad++; $display("FAIL equal_lat got=%0d exp=2", lat); end
   endtask

   task automatic test_ignored_ld();
      int lat; logic [15:0] e;
      ld8 = 1'b1; u8 = 8'd48; v8 = 8'd18;
      exp_q.push_back(euclid(16'd48, 16'd18));
      @(negedge clk);
      ld8 = 1'b0;
      repeat (2) @(negedge clk);
      ld8 = 1'b1; u8 = 8'd9; v8 = 8'd3;   // busy: must not be resampled
      @(negedge clk);
      ld8 = 1'b0;
      lat = 3;
      while (!done8 && lat < 100) begin @(negedge clk); lat++; end
      e = exp_q.pop_front();
      n_cmp++; if (res8 !== e[7:0]) begin n_bad++; $display("FAIL ignore_res got=%0d exp=%0d", res8, e); end
      n_cmp++; if (lat != 7)        begin n_bad++; $display("FAIL ignore_lat got=%0d exp=7", lat); end
      @(negedge clk);
      n_cmp++; if (busy8 !== 1'b0)  begin n_bad++; $display("FAIL ignore_no_restart got=%b exp=0", busy8); end
   endtask

   task automatic test_back_to_back();
      int lat; logic [15:0] e;
      ld8 = 1'b1; u8 = 8'd48; v8 = 8'd18;
      exp_q.push_back(euclid(16'd48, 16'd18));
      @(negedge clk);
      ld8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 100) begin @(negedge clk); lat++; end
      e = exp_q.pop_front();
      n_cmp++; if (res8 !== e[7:0]) begin n_bad++; $display("FAIL b2b_first_res got=%0d exp=%0d", res8, e); end
      // still inside the done cycle: launch the next op
      ld8 = 1'b1; u8 = 8'd17; v8 = 8'd13;
      exp_q.push_back(euclid(16'd17, 16'd13));
      @(negedge clk);
      ld8 = 1'b0;
      n_cmp++; if (busy8 !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got=%b exp=1", busy8); end
      lat = 0;
      while (!done8 && lat < 100) begin @(negedge clk); lat++; end
      e = exp_q.pop_front();
      n_cmp++; if (res8 !== e[7:0]) begin n_bad++; $display("FAIL b2b_second_res got=%0d exp=%0d", res8, e); end
      n_cmp++; if (cop8 !== 1'b1)   begin n_bad++; $display("FAIL b2b_coprime got=%b exp=1", cop8); end
      @(negedge clk);
   endtask

   task automatic test_wide_random();
      logic [15:0] r, a, b, e; logic [5:0] st; logic seen;
      drive16(16'd65535, 16'd21845, r, st, seen);
      e = exp_q.pop_front();
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL wide_done got=%b exp=1", seen); end
      n_cmp++; if (r !== e)       begin n_bad++; $display("FAIL wide_res got=%0d exp=%0d", r, e); end
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(0, 65535));
         if (i % 50 == 0) a = 16'd0;
         if (i % 4 == 1) b = b & 16'hFF00;   // extra shared factors of two
         if (i % 4 == 2) a = a & 16'hFFF0;
         drive16(a, b, r, st, seen);
         e = exp_q.pop_front();
         n_cmp++; if (seen !== 1'b1 || r !== e) begin
            n_bad++; $display("FAIL rand_res a=%0d b=%0d got=%0d exp=%0d done=%b", a, b, r, e, seen);
         end
         n_cmp++; if (st > 6'd32) begin
            n_bad++; $display("FAIL rand_steps a=%0d b=%0d got=%0d exp<=32", a, b, st);
         end
         n_cmp++; if (cop16 !== (e == 16'd1)) begin
            n_bad++; $display("FAIL rand_coprime a=%0d b=%0d got=%b exp=%b", a, b, cop16, (e == 16'd1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_mid_op_reset();
      test_basic();
      test_zero_operands();
      test_pow2_equal();
      test_ignored_ld();
      test_back_to_back();
      test_wide_random();
      n_cmp++; if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gcd_stein_n.md
Name: gcd_stein_n

Overview:
- Parametrised iterative binary (Stein) GCD engine: next generation of the 8-bit gcd block.
- Operand width is a parameter; adds busy status, zero-operand handling, coprime flag and step count for performance monitoring.
- Sits as a standalone arithmetic unit driven by a controller or bench through a ld/done handshake.
- Computes one reduction step per clock.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- SW (localparam), $clog2(2*WIDTH+1), width of the steps counter.
- KW (localparam), $clog2(WIDTH+1), width of the common power-of-two counter k.

Ports:
- clk  in  1  system clock, all state on posedge.
- resetb  in  1  asynchronous, active-high reset (1 = reset asserted, despite the name).
- ld  in  1  load request; samples u, v.
- u  in  WIDTH  operand A.
- v  in  WIDTH  operand B.
- res  out  WIDTH  GCD result; held until next completion.
- done  out  1  one-cycle pulse when res is updated.
- busy  out  1  high while computing.
- coprime  out  1  registered with res; 1 iff res == 1.
- steps  out  SW  number of reduction steps of the last operation; registered with res.

Behaviour:
- Reset (async, resetb=1): state IDLE; res=0, done=0, busy=0, coprime=0, steps=0; internal ur, vr, k, step counter cleared. Reset mid-operation aborts the computation, and no done is produced.
- States: IDLE, CALC.
- IDLE, ld=1 at edge E0: ur<=u, vr<=v, k<=0, cnt<=0, busy<=1, go to CALC. done is 0 in every cycle except the completion cycle.
- CALC: exactly one action per edge, in priority order:
  1. ur==0 or vr==0: res<=(ur|vr)<<k, steps<=cnt, coprime<=((ur|vr)<<k)==1, done<=1, busy<=0, go to IDLE (detection edge; not counted as a step).
  2. Both even: ur>>=1, vr>>=1, k++.
  3. ur even: ur>>=1.
  4. vr even: vr>>=1.
  5. Both odd, ur>=vr: ur<=(ur-vr)>>1.
  6. Both odd, ur<vr: vr<=(vr-ur)>>1.
  - Actions 2-6 increment cnt.
- Latency: done is high in the cycle after edge E0+steps+1. gcd with a zero operand has steps=0 and latency 1.
- Bound: steps <= 2*WIDTH. The subtraction is unsigned, WIDTH bits; no overflow is possible because the smaller operand is subtracted from the larger. The shift <<k fits in WIDTH because k never exceeds the trailing zeros of either operand.
- Special cases: gcd(0,0)=0 with coprime=0; gcd(0,x)=x.
- ld while busy=1 is ignored; operands are not resampled.
- ld in the same cycle as the done pulse (state IDLE at that edge) is accepted, which allows back-to-back operation.
- done and the new res/steps/coprime are updated on the same edge; busy falls on that same edge.

Test Plan (WIDTH=8 unless noted):
- Mid-op reset: ld u=48 v=18, assert resetb after 3 cycles -> busy=0, res=0, no done pulse; a subsequent ld 48/18 completes normally.
- Basic: ld u=48 v=18 -> done after 7 edges, res=6, steps=6, coprime=0; busy high for exactly 7 cycles.
- Zero operands: (0,37) -> res=37, steps=0, done 1 edge after ld. (0,0) -> res=0, coprime=0, same latency. (37,0) -> res=37.
- Power-of-two and equal operands: (128,64) -> res=64, steps=8, latency 9. (255,255) -> res=255, steps=1, latency 2.
- Handshake: ld pulsed again 2 cycles into (48,18) with u=9 v=3 -> ignored, res=6. ld asserted in the done cycle with (17,13) -> accepted, res=1, coprime=1.
- WIDTH=16 plus random regression: (65535,21845) -> res=21845. Then 1000 random pairs checked against a Euclid golden model, each with steps <= 32.
